// File: rtl/alu_exec_unit.sv
// Purpose: RV32IM ALU execute stage. Decodes ALUControl fields plus the M extension and returns a registered result.
// Latency: out_valid rises 1 cycle after accept for basic/illegal ops, MUL_CYCLES for MUL*, and XLEN+1 for DIV/REM.
// Backpressure: one operation in flight. The result is held in DONE until out_ready; in_ready returns the cycle after hand-off.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            opb5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);
    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = $clog2(XLEN + MUL_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;

    logic [XLEN-1:0]   alu_res;
    logic              alu_ill;
    logic [SHW-1:0]    shamt;
    logic              is_mext, accept;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
    logic [XLEN-1:0]   mul_res, div_res;
    logic [XLEN:0]     rem_sh, diff;
    logic              a_neg, b_neg;

    assign shamt     = src_b[SHW-1:0];
    assign is_mext   = (alu_op == 2'b10) && opb5 && funct7b0;
    assign in_ready  = (state_q == S_IDLE) && !pend_q && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign zero      = (result_q == '0);

    // Single-cycle ALU result from the live operands, captured on accept.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (alu_op)
            2'b00: alu_res = src_a + src_b;
            2'b01: alu_res = src_a - src_b;
            2'b10: begin
                unique case (funct3)
                    3'b000: alu_res = (opb5 && funct7b5) ? (src_a - src_b) : (src_a + src_b);
                    3'b001: alu_res = src_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
                    3'b100: alu_res = src_a ^ src_b;
                    3'b101: alu_res = funct7b5 ? $unsigned($signed(src_a) >>> shamt) : (src_a >> shamt);
                    3'b110: alu_res = src_a | src_b;
                    default: alu_res = src_a & src_b;
                endcase
            end
            default: begin
                if (funct3 == 3'b000) begin
                    alu_res = src_a + src_b;
                end else if (funct3 == 3'b001) begin
                    alu_res = src_b;
                end else begin
                    alu_ill = 1'b1;
                end
            end
        endcase
    end

    // Full-width product of the latched operands. MULH and MULHSU treat A as signed; only MULH treats B as signed.
    always_comb begin
        mul_a_ext = {{XLEN{(f3_q == 3'b001 || f3_q == 3'b010) && op_a_q[XLEN-1]}}, op_a_q};
        mul_b_ext = {{XLEN{(f3_q == 3'b001) && op_b_q[XLEN-1]}}, op_b_q};
        prod      = mul_a_ext * mul_b_ext;
        mul_res   = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // One restoring-division step plus the final sign fix-up. A zero divisor forces the quotient to all ones.
    always_comb begin
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        div_res = f3_q[1] ? (rneg_q ? -rem_q : rem_q)
                          : ((qneg_q && !div0_q) ? -quo_q : quo_q);
        a_neg   = !funct3[0] && src_a[XLEN-1];
        b_neg   = !funct3[0] && src_b[XLEN-1];
    end

    // Next-state logic: accept, sequencing of the multi-cycle ops, and the result hand-off.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_DONE;
                end else if (accept) begin
                    f3_d      = funct3;
                    op_a_d    = src_a;
                    op_b_d    = src_b;
                    illegal_d = 1'b0;
                    if (is_mext && !funct3[2]) begin
                        cnt_d   = CNTW'(MUL_CYCLES - 1);
                        state_d = S_MUL;
                    end else if (is_mext) begin
                        quo_d   = a_neg ? -src_a : src_a;
                        dvs_d   = b_neg ? -src_b : src_b;
                        rem_d   = '0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        div0_d  = (src_b == '0);
                        cnt_d   = CNTW'(XLEN);
                        state_d = S_DIV;
                    end else begin
                        result_d  = alu_res;
                        illegal_d = alu_ill;
                        pend_d    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers. Reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            f3_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            div0_q    <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            div0_q    <= div0_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results are queued at issue and popped at out_valid.
// Latency and busy-cycle counts are measured per operation; backpressure and mid-divide reset are exercised.
// All waits are cycle-bounded, so the run always reaches the summary line.
module tb_alu_exec_unit;
    localparam int XLEN = 32;
    localparam int MC   = 2;
    localparam int LB   = 1;
    localparam int LM   = MC;
    localparam int LD   = XLEN + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      alu_op = '0;
    logic [2:0]      funct3 = '0;
    logic            funct7b5 = 1'b0;
    logic            funct7b0 = 1'b0;
    logic            opb5 = 1'b0;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            ill;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_exec_unit #(.XLEN(XLEN), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5),
        .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=0x%h expected=0x%h", tag, what, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7b5, input logic f7b0, input logic ob5,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] er, input logic ei, input int el);
        exp_t e;
        e.res = er;
        e.ill = ei;
        e.lat = el;
        sb.push_back(e);
        @(negedge clk);
        chk(tag, "in_ready", XLEN'(in_ready), XLEN'(1));
        alu_op   = op;
        funct3   = f3;
        funct7b5 = f7b5;
        funct7b0 = f7b0;
        opb5     = ob5;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat = 0;
        int   bz  = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bz++;
        end
        chk(tag, "out_valid", XLEN'(out_valid), XLEN'(1));
        if (sb.size() == 0) begin
            e.res = 'x;
            e.ill = 1'bx;
            e.lat = -1;
        end else begin
            e = sb.pop_front();
        end
        chk(tag, "result", result, e.res);
        chk(tag, "illegal", XLEN'(illegal), XLEN'(e.ill));
        chk(tag, "zero", XLEN'(zero), XLEN'(e.res == '0));
        chk(tag, "latency", XLEN'(lat), XLEN'(e.lat));
        chk(tag, "busy_cycles", XLEN'(bz), XLEN'(e.lat - 1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            alu_op   = 2'b00;
            src_a    = $urandom;
            src_b    = $urandom;
            @(posedge clk);
            #1;
            chk(tag, "hold_valid", XLEN'(out_valid), XLEN'(1));
            chk(tag, "hold_result", result, e.res);
            chk(tag, "hold_in_ready", XLEN'(in_ready), XLEN'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk(tag, "release_valid", XLEN'(out_valid), XLEN'(0));
        chk(tag, "release_in_ready", XLEN'(in_ready), XLEN'(1));
    endtask

    initial begin
        // Reset state while reset is asserted, then in_ready once released.
        #3;
        chk("reset", "result", result, '0);
        chk("reset", "zero", XLEN'(zero), XLEN'(1));
        chk("reset", "out_valid", XLEN'(out_valid), XLEN'(0));
        chk("reset", "busy", XLEN'(busy), XLEN'(0));
        chk("reset", "illegal", XLEN'(illegal), XLEN'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("reset", "in_ready", XLEN'(in_ready), XLEN'(1));

        // Basic ALU operations.
        issue("add", 2'b00, 3'b000, 0, 0, 0, 32'd5, 32'd7, 32'd12, 0, LB);                            collect("add", 0);
        issue("sub_r", 2'b10, 3'b000, 1, 0, 1, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, LB);                    collect("sub_r", 0);
        issue("addi_f7", 2'b10, 3'b000, 1, 0, 0, 32'd3, 32'd5, 32'd8, 0, LB);                          collect("addi_f7", 0);
        issue("sub_op01", 2'b01, 3'b000, 0, 0, 0, 32'd10, 32'd10, 32'd0, 0, LB);                      collect("sub_op01", 0);
        issue("sra", 2'b10, 3'b101, 1, 0, 1, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, LB);              collect("sra", 0);
        issue("srl", 2'b10, 3'b101, 0, 0, 1, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, LB);              collect("srl", 0);
        issue("sll", 2'b10, 3'b001, 0, 0, 1, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 0, LB);      collect("sll", 0);
        issue("slt", 2'b10, 3'b010, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, LB);                      collect("slt", 0);
        issue("sltu", 2'b10, 3'b011, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, LB);                     collect("sltu", 0);
        issue("or", 2'b10, 3'b110, 0, 0, 1, 32'h00F0_0F00, 32'h0F00_00F0, 32'h0FF0_0FF0, 0, LB);       collect("or", 0);
        issue("and", 2'b10, 3'b111, 0, 0, 1, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, LB);      collect("and", 0);

        // Multiply.
        issue("mulh", 2'b10, 3'b001, 0, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, LM);     collect("mulh", 0);
        issue("mul", 2'b10, 3'b000, 0, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0, LM);      collect("mul", 0);
        issue("mulhu", 2'b10, 3'b011, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, LM);    collect("mulhu", 0);
        issue("mulhsu", 2'b10, 3'b010, 0, 1, 1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, LM);           collect("mulhsu", 0);
        issue("mul_lo", 2'b10, 3'b000, 0, 1, 1, 32'd1234, 32'd5678, 32'd7006652, 0, LM);               collect("mul_lo", 0);

        // Divide and remainder, including divide-by-zero and signed overflow.
        issue("div", 2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, LD);              collect("div", 0);
        issue("rem", 2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, LD);              collect("rem", 0);
        issue("divu0", 2'b10, 3'b101, 0, 1, 1, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, LD);                    collect("divu0", 0);
        issue("remu0", 2'b10, 3'b111, 0, 1, 1, 32'd7, 32'd0, 32'd7, 0, LD);                            collect("remu0", 0);
        issue("div_ovf", 2'b10, 3'b100, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, LD);  collect("div_ovf", 0);
        issue("rem_ovf", 2'b10, 3'b110, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, LD);          collect("rem_ovf", 0);
        issue("div_s0", 2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, LD);           collect("div_s0", 0);
        issue("rem_s0", 2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, LD);           collect("rem_s0", 0);
        issue("divu", 2'b10, 3'b101, 0, 1, 1, 32'd100, 32'd7, 32'd14, 0, LD);                          collect("divu", 0);

        // Backpressure: result held five cycles while in_valid pulses are ignored.
        issue("bp_xor", 2'b10, 3'b100, 0, 0, 1, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 0, LB);   collect("bp_xor", 5);

        // Reset during a divide aborts it; the next operation proceeds normally.
        issue("abort", 2'b10, 3'b101, 0, 1, 1, 32'd1000, 32'd3, 32'd333, 0, LD);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset", "result", result, '0);
        chk("mid_reset", "zero", XLEN'(zero), XLEN'(1));
        chk("mid_reset", "out_valid", XLEN'(out_valid), XLEN'(0));
        chk("mid_reset", "busy", XLEN'(busy), XLEN'(0));
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1 chk("mid_reset", "in_ready", XLEN'(in_ready), XLEN'(1));
        issue("post_add", 2'b00, 3'b000, 0, 0, 0, 32'd1, 32'd1, 32'd2, 0, LB);                         collect("post_add", 0);

        // Upper-immediate and illegal decode.
        issue("auipc", 2'b11, 3'b000, 0, 0, 0, 32'h0000_1000, 32'h0000_5000, 32'h0000_6000, 0, LB);    collect("auipc", 0);
        issue("lui", 2'b11, 3'b001, 0, 0, 0, 32'h0000_1000, 32'h1234_5000, 32'h1234_5000, 0, LB);      collect("lui", 0);
        issue("illegal", 2'b11, 3'b010, 0, 0, 0, 32'h0000_1000, 32'h0000_5000, 32'h0000_0000, 1, LB);  collect("illegal", 0);
        issue("after_ill", 2'b00, 3'b000, 0, 0, 0, 32'd40, 32'd2, 32'd42, 0, LB);                      collect("after_ill", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, handshaked ALU execute stage for the single-cycle/multi-cycle RV core.
- Decodes ALUOp/funct3/funct7 fields with the existing ALUControl encoding, extended with RV32M MUL/DIV ops.
- Executes the operation on src_a/src_b and returns a registered result through a valid/ready interface.
- Basic ops complete in 1 cycle, multiply in MUL_CYCLES cycles, divide/remainder through an iterative XLEN-step divider.

Parameters:
- XLEN, 32, datapath width; power of 2, >= 8. Shift amount is src_b[$clog2(XLEN)-1:0].
- MUL_CYCLES, 2, accept-to-out_valid latency for MUL* ops; >= 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE with no pending result.
- alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 upper-immediate.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- funct7b0  in  1  instr[25]; M-extension select.
- opb5  in  1  opcode bit 5 (1 = R-type).
- src_a  in  XLEN  operand A (PC for AUIPC).
- src_b  in  XLEN  operand B / immediate.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0.
- illegal  out  1  undefined decode; result forced to 0.
- busy  out  1  high in MUL or DIV state.

Behaviour:
- Reset (async, any state):
  - FSM -> IDLE.
  - result = 0; zero = 1; illegal = 0; out_valid = 0; busy = 0; in_ready = 1 once reset is released.
  - Any in-flight MUL/DIV is aborted; no result is emitted.
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid & in_ready at a rising edge; operands and decode are latched at that edge (call it t).
- Decode, alu_op=10 with opb5 & funct7b0 (M-ext), by funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU -> MUL state.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU -> DIV state.
- Decode, all other alu_op=10 cases:
  - 000: SUB if opb5 & funct7b5, else ADD.
  - 001: SLL. 010: SLT (signed). 011: SLTU. 100: XOR.
  - 101: SRA if funct7b5, else SRL.
  - 110: OR. 111: AND.
- Decode, alu_op=00/01: ADD / SUB.
- Decode, alu_op=11:
  - funct3=000 AUIPC: src_a + src_b.
  - funct3=001 LUI: src_b.
  - any other funct3: illegal=1, result=0, 1-cycle path.
- Latency: out_valid rises after the edge at t+1 (basic/illegal), t+MUL_CYCLES (MUL), t+XLEN+1 (DIV).
- MUL:
  - Full 2*XLEN product with operand signedness per op (MULHSU: a signed, b unsigned).
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Down-counter from MUL_CYCLES-1; MUL_CYCLES=1 goes straight to DONE.
- DIV:
  - Restoring radix-2 on magnitudes: one quotient bit per cycle, XLEN iterations, then sign fix-up in the final cycle.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1); remainder = 0.
  - Special cases still take the full XLEN+1 latency.
- DONE:
  - out_valid=1; result, zero and illegal are held stable while out_ready=0.
  - On out_valid & out_ready -> IDLE; in_ready is asserted from the next cycle (no same-cycle re-accept).
- Single outstanding operation.
- All arithmetic is modulo 2^XLEN.
- Input changes while in_ready=0 are ignored.
- Arithmetic shift replicates src_a[XLEN-1].

Test Plan:
- Basic ALU ops:
  - ADD 5+7 -> result 12 at t+1.
  - R-type SUB 3-5 -> 0xFFFFFFFE.
  - I-type funct7b5=1, opb5=0, funct3=000 -> ADD, not SUB.
  - SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000.
  - SLT -1<1 -> 1; SLTU -> 0.
- Multiply, MUL_CYCLES=2:
  - MULH 0x80000000 * 0x80000000 -> 0x40000000; MUL -> 0.
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
  - out_valid exactly at t+2.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU 7/0 -> 0xFFFFFFFF; REMU -> 7.
  - DIV 0x80000000 / -1 -> 0x80000000, REM 0.
  - Each divide: out_valid at t+33, busy high during iteration.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result -> result/out_valid stable, in_ready=0.
  - in_valid pulses during that window are ignored.
  - Release -> in_ready=1 the next cycle.
- Reset mid-DIV:
  - Assert reset at iteration 10 -> outputs 0/zero=1 immediately (async).
  - After release, a new ADD 1+1 -> 2 at t+1.
- Upper-immediate and illegal:
  - AUIPC src_a=0x1000, src_b=0x5000 -> 0x6000.
  - LUI -> src_b.
  - alu_op=11, funct3=010 -> illegal=1, result=0, zero=1.
